// File: rtl/oz_pkg.sv
// Shared types for the oz colouring checker and its enumerator.
package oz_pkg;

  localparam int COLOR_W  = 2;
  localparam int NREGIONS = 5;
  localparam int IDX_W    = COLOR_W * NREGIONS;

  // One colour per region; gc is the most significant field.
  typedef struct packed {
    logic [COLOR_W-1:0] gc;
    logic [COLOR_W-1:0] wc;
    logic [COLOR_W-1:0] qc;
    logic [COLOR_W-1:0] mc;
    logic [COLOR_W-1:0] ec;
  } coloring_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } search_state_e;

endpackage

// File: rtl/oz.sv
// Combinational map-colouring checker for the Land of Oz.
// The four countries form a ring (Gillikin-Winkie-Quadling-Munchkin) and the
// Emerald City in the middle borders all of them.
module oz
  import oz_pkg::*;
(
  input  coloring_t col,
  output logic      valid
);

  logic ring_ok;
  logic center_ok;

  // Neighbouring countries on the ring must differ.
  assign ring_ok = (col.gc != col.wc) && (col.wc != col.qc) &&
                   (col.qc != col.mc) && (col.mc != col.gc);

  // The Emerald City borders every country.
  assign center_ok = (col.ec != col.gc) && (col.ec != col.wc) &&
                     (col.ec != col.qc) && (col.ec != col.mc);

  assign valid = ring_ok && center_ok;

endmodule

// File: rtl/oz_search.sv
// Sequential enumerator in front of the oz checker: walks all 1024 colour
// assignments in ascending order and streams the passing ones out over a
// valid/ready handshake, then reports how many were found.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// SCAN  | evaluating idx, one candidate per cycle (stalls on backpressure)
// DRAIN | all candidates consumed, waiting for the last solution to leave
// DONE  | scan complete, done/found/sol_count held until the next start
module oz_search
  import oz_pkg::*;
#(
  parameter int NCOLORS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [10:0]       sol_count,
  output logic              sol_valid,
  input  logic              sol_ready,
  output logic [IDX_W-1:0]  sol_color
);

  localparam logic [COLOR_W:0]  NC      = (COLOR_W + 1)'(NCOLORS);
  localparam logic [IDX_W-1:0]  IDX_MAX = '1;

  search_state_e    state;
  logic [IDX_W-1:0] idx;
  coloring_t        cand;
  logic             cand_ok;
  logic             in_range;
  logic             pass;
  logic             out_free;

  assign cand = coloring_t'(idx);

  oz u_oz (
    .col   (cand),
    .valid (cand_ok)
  );

  // Reject any candidate that uses a colour outside the configured palette.
  assign in_range = ({1'b0, cand.gc} < NC) && ({1'b0, cand.wc} < NC) &&
                    ({1'b0, cand.qc} < NC) && ({1'b0, cand.mc} < NC) &&
                    ({1'b0, cand.ec} < NC);

  assign pass     = cand_ok && in_range;
  assign out_free = !sol_valid || sol_ready;

  // Scan FSM with registered status outputs and the output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      sol_count <= '0;
      sol_valid <= 1'b0;
      sol_color <= '0;
    end else begin
      // A completed transfer empties the register unless a new load below
      // refills it in the same cycle.
      if (sol_valid && sol_ready) sol_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SCAN;
            idx       <= '0;
            sol_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            found     <= 1'b0;
          end
        end
        SCAN: begin
          // A passing candidate waits for room; a failing one never stalls.
          if (!pass || out_free) begin
            if (pass) begin
              sol_color <= cand;
              sol_valid <= 1'b1;
              sol_count <= sol_count + 11'd1;
            end
            if (idx == IDX_MAX) state <= DRAIN;
            else                idx   <= idx + 1'b1;
          end
        end
        DRAIN: begin
          if (out_free) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= (sol_count != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oz_search.sv
// Self-checking bench for oz_search: three instances (4, 3 and 2 colours)
// compared against a list-based model of the Oz map colouring problem.
module tb_oz_search;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [2:0]  ready_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  found_v;
  logic [2:0]  valid_v;
  logic [10:0] count_v [3];
  logic [9:0]  color_v [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model tables
  bit pass_tab [3][1024];
  int pref     [3][1025];

  // per-instance checking mode: 0 none, 1 cycle-exact (ready high), 2 queue
  int mode   [3];
  int tstart [3];
  int expq   [$];
  bit hold_prev;
  logic [9:0] prev_color;
  bit   got_first;
  logic [9:0] first_col, last_col;
  int   u2_pulses;

  oz_search #(.NCOLORS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .found(found_v[0]), .sol_count(count_v[0]),
    .sol_valid(valid_v[0]), .sol_ready(ready_v[0]), .sol_color(color_v[0]));

  oz_search #(.NCOLORS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .found(found_v[1]), .sol_count(count_v[1]),
    .sol_valid(valid_v[1]), .sol_ready(ready_v[1]), .sol_color(color_v[1]));

  oz_search #(.NCOLORS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .found(found_v[2]), .sol_count(count_v[2]),
    .sol_valid(valid_v[2]), .sol_ready(ready_v[2]), .sol_color(color_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wheel map: G-W-Q-M ring, E touches all four; colours must be < nc.
  function automatic bit model_pass(int i, int nc);
    int g = (i >> 8) & 3;
    int w = (i >> 6) & 3;
    int q = (i >> 4) & 3;
    int m = (i >> 2) & 3;
    int e = i & 3;
    if (g >= nc || w >= nc || q >= nc || m >= nc || e >= nc) return 1'b0;
    return (g != w) && (w != q) && (q != m) && (m != g) &&
           (e != g) && (e != w) && (e != q) && (e != m);
  endfunction

  task automatic check_reset_vals(input int k, input string tag);
    chk($sformatf("%s_u%0d_busy", tag, k),  32'(busy_v[k]),  0);
    chk($sformatf("%s_u%0d_done", tag, k),  32'(done_v[k]),  0);
    chk($sformatf("%s_u%0d_found", tag, k), 32'(found_v[k]), 0);
    chk($sformatf("%s_u%0d_count", tag, k), 32'(count_v[k]), 0);
    chk($sformatf("%s_u%0d_valid", tag, k), 32'(valid_v[k]), 0);
    chk($sformatf("%s_u%0d_color", tag, k), 32'(color_v[k]), 0);
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && mode[k] == 1) begin
        int kk;
        bit ev;
        kk = cyc - tstart[k];
        if (kk >= 0 && kk <= 1030) begin
          ev = (kk >= 1 && kk <= 1024) ? pass_tab[k][kk-1] : 1'b0;
          chk($sformatf("u%0d_valid_k%0d", k, kk), 32'(valid_v[k]), 32'(ev));
          if (ev) chk($sformatf("u%0d_color_k%0d", k, kk), 32'(color_v[k]), 32'(kk - 1));
          chk($sformatf("u%0d_busy_k%0d", k, kk), 32'(busy_v[k]), 32'(kk <= 1024));
          chk($sformatf("u%0d_done_k%0d", k, kk), 32'(done_v[k]), 32'(kk >= 1025));
          chk($sformatf("u%0d_found_k%0d", k, kk), 32'(found_v[k]),
              32'(kk >= 1025 && pref[k][1024] != 0));
          chk($sformatf("u%0d_count_k%0d", k, kk), 32'(count_v[k]),
              32'(pref[k][(kk > 1024) ? 1024 : kk]));
          if (valid_v[k] === 1'b1) begin
            if (k == 0) begin
              if (!got_first) begin
                first_col = color_v[0];
                got_first = 1'b1;
              end
              last_col = color_v[0];
            end
            if (k == 2) u2_pulses++;
          end
        end
      end else if (rst_n && mode[k] == 2) begin
        if (hold_prev) begin
          chk($sformatf("u%0d_stall_valid", k), 32'(valid_v[k]), 1);
          chk($sformatf("u%0d_stall_color", k), 32'(color_v[k]), 32'(prev_color));
        end
        if (valid_v[k] === 1'b1 && ready_v[k] === 1'b1) begin
          if (expq.size() == 0) begin
            chk($sformatf("u%0d_extra_solution", k), 32'(color_v[k]), 32'hFFFF_FFFF);
          end else begin
            chk($sformatf("u%0d_stream_color", k), 32'(color_v[k]), 32'(expq.pop_front()));
          end
        end
        hold_prev  = (valid_v[k] === 1'b1) && (ready_v[k] === 1'b0);
        prev_color = color_v[k];
      end
    end
  end

  initial begin
    int first_idx, last_idx;
    bit fin;

    rst_n     = 1'b0;
    start_v   = '0;
    ready_v   = 3'b111;
    hold_prev = 1'b0;
    got_first = 1'b0;
    u2_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      mode[k]   = 0;
      tstart[k] = 0;
      pref[k][0] = 0;
      for (int i = 0; i < 1024; i++) begin
        pass_tab[k][i] = model_pass(i, 4 - k);
        pref[k][i+1]   = pref[k][i] + int'(pass_tab[k][i]);
      end
    end

    // Hand-computed pins on the model itself.
    first_idx = -1;
    last_idx  = -1;
    for (int i = 0; i < 1024; i++)
      if (pass_tab[0][i]) begin
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
    chk("model_n4_count", 32'(pref[0][1024]), 72);
    chk("model_n3_count", 32'(pref[1][1024]), 6);
    chk("model_n2_count", 32'(pref[2][1024]), 0);
    chk("model_n4_first", 32'(first_idx), 32'h046);
    chk("model_n4_last",  32'(last_idx),  32'h3B9);

    #2;
    for (int k = 0; k < 3; k++) check_reset_vals(k, "por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Phase 1: all three instances, ready tied high, cycle-exact model.
    @(posedge clk); #1;
    start_v = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tstart[k] = cyc + 1;
      mode[k]   = 1;
    end
    @(posedge clk); #1;
    start_v = '0;
    repeat (1031) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) mode[k] = 0;
    chk("p1_u4_count", 32'(count_v[0]), 72);
    chk("p1_u4_found", 32'(found_v[0]), 1);
    chk("p1_u4_done",  32'(done_v[0]),  1);
    chk("p1_u4_first", 32'(first_col),  32'h046);
    chk("p1_u4_last",  32'(last_col),   32'h3B9);
    chk("p1_u3_count", 32'(count_v[1]), 6);
    chk("p1_u3_found", 32'(found_v[1]), 1);
    chk("p1_u2_count", 32'(count_v[2]), 0);
    chk("p1_u2_found", 32'(found_v[2]), 0);
    chk("p1_u2_pulses", 32'(u2_pulses), 0);

    // Phase 2: 4 colours with random ~30% ready, ordered stream check.
    expq.delete();
    for (int i = 0; i < 1024; i++) if (pass_tab[0][i]) expq.push_back(i);
    hold_prev   = 1'b0;
    ready_v[0]  = 1'b0;
    mode[0]     = 2;
    start_v[0]  = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      ready_v[0] = ($urandom_range(0, 9) < 3);
      if (done_v[0] === 1'b1) fin = 1'b1;
    end
    chk("p2_done_reached", 32'(done_v[0]), 1);
    @(posedge clk); #1;
    mode[0]    = 0;
    ready_v[0] = 1'b1;
    chk("p2_remaining", 32'(expq.size()), 0);
    chk("p2_count", 32'(count_v[0]), 72);
    chk("p2_found", 32'(found_v[0]), 1);

    // Phase 3: start while busy is ignored, then reset mid-scan.
    @(posedge clk); #1;
    tstart[0]  = cyc + 1;
    mode[0]    = 1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("p3_busy_before_restart", 32'(busy_v[0]), 1);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (398) @(posedge clk);
    #1;
    mode[0] = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k, "midscan_rst");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fresh start after reset must repeat the full result exactly.
    got_first = 1'b0;
    @(posedge clk); #1;
    tstart[0]  = cyc + 1;
    mode[0]    = 1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (1031) @(posedge clk);
    #1;
    mode[0] = 0;
    chk("p3_count", 32'(count_v[0]), 72);
    chk("p3_found", 32'(found_v[0]), 1);
    chk("p3_first", 32'(first_col),  32'h046);
    chk("p3_last",  32'(last_col),   32'h3B9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
